cv32e40x_div: RTL and testbench

CV32E40X_DIV -- requirements
Module: cv32e40x_div

---
 rtl/cv32e40x_pkg.sv | 29 ++
 rtl/cv32e40x_div.sv | 155 +++++++++++++++
 tb/tb_cv32e40x_div.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cv32e40x_pkg.sv
// Shared types for the iterative divider: opcodes, FSM states and helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cv32e40x_pkg;

    typedef enum logic [1:0] {
        DIV_DIVU = 2'd0,
        DIV_DIV  = 2'd1,
        DIV_REMU = 2'd2,
        DIV_REM  = 2'd3
    } div_opcode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INIT   = 2'd1,
        COMP   = 2'd2,
        FINISH = 2'd3
    } div_state_e;

    // Signed operators work on magnitudes and fix up the sign at the end.
    function automatic logic div_is_signed(input div_opcode_e op);
        return (op == DIV_DIV) || (op == DIV_REM);
    endfunction

    function automatic logic div_is_rem(input div_opcode_e op);
        return (op == DIV_REMU) || (op == DIV_REM);
    endfunction

endpackage

// File: rtl/cv32e40x_div.sv
// Restoring 32-bit divider (DIV/DIVU/REM/REMU) borrowing the ALU's CLZ and shifter.
// Latency: valid_o clz(|b|)+3 cycles after accept, 2 cycles for a zero divisor.
// Backpressure: result held stable in FINISH until ready_i; ready_o only in IDLE.
module cv32e40x_div
    import cv32e40x_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  div_opcode_e        operator_i,
    input  logic [31:0]        op_a_i,
    input  logic [31:0]        op_b_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [31:0]        result_o,
    input  logic               kill_i,
    output logic               alu_clz_en_o,
    output logic [31:0]        alu_clz_data_o,
    input  logic [5:0]         alu_clz_result_i,
    output logic               alu_shift_en_o,
    output logic [31:0]        alu_shift_op_o,
    output logic [5:0]         alu_shift_amt_o,
    input  logic [31:0]        alu_op_shifted_i
);

    div_state_e   state;
    div_opcode_e  operator_q;
    logic [31:0]  b_mag_q;
    logic [31:0]  remainder_q;
    logic [31:0]  divisor_q;
    logic [31:0]  quotient_q;
    logic [5:0]   cnt_q;
    logic         res_neg_q;

    logic [31:0]  a_mag;
    logic [31:0]  b_mag;
    logic         res_neg;
    logic [32:0]  diff;
    logic         rem_ge_div;
    logic [31:0]  raw_result;
    logic [31:0]  final_result;

    // Operand magnitudes and result sign, captured on accept.
    always_comb begin
        a_mag   = (div_is_signed(operator_i) && op_a_i[31]) ? -op_a_i : op_a_i;
        b_mag   = (div_is_signed(operator_i) && op_b_i[31]) ? -op_b_i : op_b_i;
        res_neg = 1'b0;
        if (operator_i == DIV_DIV) begin
            // A zero divisor must yield all-ones, so it never negates.
            res_neg = (op_a_i[31] ^ op_b_i[31]) && (op_b_i != 32'd0);
        end else if (operator_i == DIV_REM) begin
            res_neg = op_a_i[31];
        end
    end

    // The single subtractor: its borrow doubles as the remainder >= divisor compare.
    always_comb begin
        diff       = {1'b0, remainder_q} - {1'b0, divisor_q};
        rem_ge_div = ~diff[32];
    end

    // Result selection and sign fix-up; a zero divisor forces the quotient to all ones.
    always_comb begin
        if (div_is_rem(operator_q)) begin
            raw_result = remainder_q;
        end else if (b_mag_q == 32'd0) begin
            raw_result = 32'hFFFF_FFFF;
        end else begin
            raw_result = quotient_q;
        end
        final_result = res_neg_q ? -raw_result : raw_result;
    end

    // ALU borrow is limited to INIT; everything reads zero otherwise.
    always_comb begin
        ready_o         = (state == IDLE);
        alu_clz_en_o    = 1'b0;
        alu_clz_data_o  = 32'd0;
        alu_shift_en_o  = 1'b0;
        alu_shift_op_o  = 32'd0;
        alu_shift_amt_o = 6'd0;
        if (state == INIT) begin
            alu_clz_en_o    = 1'b1;
            alu_clz_data_o  = b_mag_q;
            alu_shift_en_o  = 1'b1;
            alu_shift_op_o  = b_mag_q;
            alu_shift_amt_o = alu_clz_result_i;
        end
    end

    // Control FSM with datapath registers; kill overrides every transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            operator_q  <= DIV_DIVU;
            b_mag_q     <= 32'd0;
            remainder_q <= 32'd0;
            divisor_q   <= 32'd0;
            quotient_q  <= 32'd0;
            cnt_q       <= 6'd0;
            res_neg_q   <= 1'b0;
            valid_o     <= 1'b0;
            result_o    <= 32'd0;
        end else if (kill_i) begin
            state    <= IDLE;
            valid_o  <= 1'b0;
            result_o <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        state       <= INIT;
                        operator_q  <= operator_i;
                        remainder_q <= a_mag;
                        b_mag_q     <= b_mag;
                        quotient_q  <= 32'd0;
                        res_neg_q   <= res_neg;
                    end
                end
                INIT: begin
                    // Normalise the divisor so its MSB sits at bit 31.
                    divisor_q <= alu_op_shifted_i;
                    cnt_q     <= alu_clz_result_i;
                    state     <= (b_mag_q == 32'd0) ? FINISH : COMP;
                end
                COMP: begin
                    if (rem_ge_div) begin
                        remainder_q <= diff[31:0];
                    end
                    quotient_q <= {quotient_q[30:0], rem_ge_div};
                    divisor_q  <= {1'b0, divisor_q[31:1]};
                    if (cnt_q == 6'd0) begin
                        state <= FINISH;
                    end else begin
                        cnt_q <= cnt_q - 6'd1;
                    end
                end
                FINISH: begin
                    // First FINISH cycle registers the result; then wait for the consumer.
                    if (!valid_o) begin
                        valid_o  <= 1'b1;
                        result_o <= final_result;
                    end else if (ready_i) begin
                        valid_o  <= 1'b0;
                        result_o <= 32'd0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cv32e40x_div.sv
// Randomised + directed bench for cv32e40x_div with an ALU CLZ/shift model.
// Latency: checks exact accept-to-valid cycle count per operation.
// Backpressure: exercises ready_i hold-off, kill and mid-operation reset.
module tb_cv32e40x_div;
    import cv32e40x_pkg::*;

    logic         clk;
    logic         rst_n;
    div_opcode_e  operator_i;
    logic [31:0]  op_a_i;
    logic [31:0]  op_b_i;
    logic         valid_i;
    logic         ready_o;
    logic         valid_o;
    logic         ready_i;
    logic [31:0]  result_o;
    logic         kill_i;
    logic         alu_clz_en_o;
    logic [31:0]  alu_clz_data_o;
    logic [5:0]   alu_clz_result_i;
    logic         alu_shift_en_o;
    logic [31:0]  alu_shift_op_o;
    logic [5:0]   alu_shift_amt_o;
    logic [31:0]  alu_op_shifted_i;

    int checks = 0;
    int errors = 0;

    cv32e40x_div dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .operator_i       (operator_i),
        .op_a_i           (op_a_i),
        .op_b_i           (op_b_i),
        .valid_i          (valid_i),
        .ready_o          (ready_o),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .result_o         (result_o),
        .kill_i           (kill_i),
        .alu_clz_en_o     (alu_clz_en_o),
        .alu_clz_data_o   (alu_clz_data_o),
        .alu_clz_result_i (alu_clz_result_i),
        .alu_shift_en_o   (alu_shift_en_o),
        .alu_shift_op_o   (alu_shift_op_o),
        .alu_shift_amt_o  (alu_shift_amt_o),
        .alu_op_shifted_i (alu_op_shifted_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] clz(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) return 6'(31 - i);
        end
        return 6'd32;
    endfunction

    // Shared ALU: CLZ and left shifter, only answering while the divider owns them.
    always_comb begin
        alu_clz_result_i = 6'd0;
        alu_op_shifted_i = 32'd0;
        if (alu_clz_en_o)   alu_clz_result_i = clz(alu_clz_data_o);
        if (alu_shift_en_o) alu_op_shifted_i = alu_shift_op_o << alu_shift_amt_o[4:0];
    end

    function automatic logic [31:0] ref_result(input div_opcode_e op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (op)
            DIV_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            DIV_REMU: return (b == 0) ? a : a % b;
            DIV_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            default: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
        endcase
    endfunction

    function automatic int ref_latency(input div_opcode_e op, input logic [31:0] b);
        logic [31:0] m;
        m = ((op == DIV_DIV || op == DIV_REM) && b[31]) ? -b : b;
        if (b == 0) return 2;
        return int'(clz(m)) + 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called one step after a rising edge; returns at the same phase, back in IDLE.
    task automatic run_op(input div_opcode_e op, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] exp;
        logic [31:0] held;
        int          exp_lat;
        int          cyc;
        int          init_cyc;
        logic        bad;
        exp     = ref_result(op, a, b);
        exp_lat = ref_latency(op, b);
        check("ready_before", 32'(ready_o), 32'd1);
        operator_i = op;
        op_a_i     = a;
        op_b_i     = b;
        valid_i    = 1'b1;
        ready_i    = (hold == 0);
        @(posedge clk); #1;
        valid_i = 1'b0;
        op_a_i  = $urandom;
        op_b_i  = $urandom;
        cyc = 0;
        init_cyc = 0;
        bad = 1'b0;
        while (!valid_o && cyc < 100) begin
            if (result_o != 0 || ready_o) bad = 1'b1;
            if (alu_clz_en_o) init_cyc++;
            @(posedge clk); #1;
            cyc++;
        end
        check($sformatf("latency %s %h/%h", op.name(), a, b), 32'(cyc), 32'(exp_lat));
        check($sformatf("result %s %h/%h", op.name(), a, b), result_o, exp);
        check("quiet_while_busy", 32'(bad), 32'd0);
        check("alu_owned_one_cycle", 32'(init_cyc), 32'd1);
        held = result_o;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(valid_o), 32'd1);
            check("hold_result", result_o, held);
            check("hold_ready", 32'(ready_o), 32'd0);
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        check("after_valid", 32'(valid_o), 32'd0);
        check("after_ready", 32'(ready_o), 32'd1);
        check("after_result", result_o, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(ready_o), 32'd1);
        check({tag, "_valid"}, 32'(valid_o), 32'd0);
        check({tag, "_result"}, result_o, 32'd0);
        check({tag, "_alu_en"}, {30'd0, alu_clz_en_o, alu_shift_en_o}, 32'd0);
        check({tag, "_alu_dat"}, alu_clz_data_o | alu_shift_op_o | 32'(alu_shift_amt_o), 32'd0);
    endtask

    initial begin
        int seen;
        int sel;
        logic [31:0] a;
        logic [31:0] b;
        div_opcode_e op;

        rst_n      = 1'b0;
        operator_i = DIV_DIVU;
        op_a_i     = 32'd0;
        op_b_i     = 32'd0;
        valid_i    = 1'b0;
        ready_i    = 1'b1;
        kill_i     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed corner cases
        run_op(DIV_DIVU, 32'd100, 32'd7, 0);
        run_op(DIV_REMU, 32'd100, 32'd7, 0);
        run_op(DIV_DIV,  -32'sd7, 32'd2, 0);
        run_op(DIV_REM,  -32'sd7, 32'd2, 0);
        run_op(DIV_DIV,  32'd7, -32'sd2, 0);
        run_op(DIV_DIVU, 32'h1234, 32'd0, 0);
        run_op(DIV_REM,  32'h1234, 32'd0, 0);
        run_op(DIV_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(DIV_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(DIV_DIVU, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(DIV_REMU, 32'd100, 32'd7, 5);

        // Kill on the third COMP cycle
        operator_i = DIV_DIVU; op_a_i = 32'd100; op_b_i = 32'd7; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        kill_i = 1'b1;
        @(posedge clk); #1;
        kill_i = 1'b0;
        check("kill_ready", 32'(ready_o), 32'd1);
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (valid_o) seen++; end
        check("kill_no_valid", 32'(seen), 32'd0);

        // Kill coinciding with a request drops it
        operator_i = DIV_DIVU; op_a_i = 32'd50; op_b_i = 32'd3; valid_i = 1'b1; kill_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0; kill_i = 1'b0;
        check("kill_accept_ready", 32'(ready_o), 32'd1);
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (valid_o || alu_clz_en_o) seen++; end
        check("kill_accept_dropped", 32'(seen), 32'd0);

        // Reset in the middle of COMP
        operator_i = DIV_DIVU; op_a_i = 32'd1000; op_b_i = 32'd9; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_comp");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(DIV_DIV, 32'd1000, -32'sd9, 0);

        // Reset while a result is held by backpressure
        ready_i = 1'b0;
        operator_i = DIV_REMU; op_a_i = 32'd77; op_b_i = 32'd5; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        seen = 0;
        while (!valid_o && seen < 100) begin @(posedge clk); #1; seen++; end
        check("rst_fin_valid_before", 32'(valid_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_finish");
        ready_i = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Randomised operations with mixed operand classes and hold-off
        for (int n = 0; n < 150; n++) begin
            op  = div_opcode_e'($urandom_range(0, 3));
            sel = $urandom_range(0, 5);
            a   = $urandom;
            b   = $urandom;
            case (sel)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: ;
                4: b = b >> $urandom_range(0, 31);
                default: a = $urandom_range(0, 255);
            endcase
            run_op(op, a, b, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
